// File: rtl/mux_sched_pkg.sv
// rtl/mux_sched_pkg.sv - shared constants and round-robin helper for the lane scheduler
package mux_sched_pkg;

  localparam int NUM_LANES = 4;
  localparam int WORD_W    = 9;
  localparam int VALID_BIT = 8;
  localparam int LANE_W    = 2;

  localparam logic [WORD_W-1:0] IDLE_WORD = 9'h000;

  // NUM_LANES == 2**LANE_W, so the natural wrap of the add is the modulo.
  function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
    return lane + LANE_W'(1);
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane word FIFO with registered occupancy count
module lane_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int WORD_W = 9,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mux_lane_scheduler.sv
// rtl/mux_lane_scheduler.sv - round-robin / strict-priority merge of four lanes onto one registered word
module mux_lane_scheduler
  import mux_sched_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int PRIO_MODE_EN = 1,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                       clk4f,
  input  logic                       reset,
  input  logic [WORD_W-1:0]          data0,
  input  logic [WORD_W-1:0]          data1,
  input  logic [WORD_W-1:0]          data2,
  input  logic [WORD_W-1:0]          data3,
  output logic [NUM_LANES-1:0]       in_ready,
  input  logic                       out_pause,
  input  logic                       prio_mode,
  output logic [WORD_W-1:0]          data_out,
  output logic [LANE_W-1:0]          out_lane,
  output logic [NUM_LANES*CNT_W-1:0] occupancy
);

  logic [WORD_W-1:0]    din  [NUM_LANES];
  logic [WORD_W-1:0]    head [NUM_LANES];
  logic [CNT_W-1:0]     cnt  [NUM_LANES];
  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] empty;
  logic [NUM_LANES-1:0] pop;
  logic [LANE_W-1:0]    last_grant;
  logic [LANE_W-1:0]    grant_lane;
  logic [LANE_W-1:0]    cand;
  logic                 grant_valid;
  logic [WORD_W-1:0]    head_sel;

  assign din[0] = data0;
  assign din[1] = data1;
  assign din[2] = data2;
  assign din[3] = data3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign in_ready[i] = !full[i];
    assign pop[i]      = !out_pause && grant_valid && (grant_lane == LANE_W'(i));
    assign occupancy[i*CNT_W +: CNT_W] = cnt[i];

    lane_fifo #(
      .DEPTH  (DEPTH),
      .WORD_W (WORD_W)
    ) u_fifo (
      .clk   (clk4f),
      .reset (reset),
      .push  (din[i][VALID_BIT]),
      .pop   (pop[i]),
      .wdata (din[i]),
      .head  (head[i]),
      .count (cnt[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Priority scans downward so the lowest non-empty index is the last one written.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = last_grant;
    cand        = last_grant;
    if (prio_mode && (PRIO_MODE_EN != 0)) begin
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (!empty[i]) begin
          grant_valid = 1'b1;
          grant_lane  = LANE_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        cand = next_lane(cand);
        if (!grant_valid && !empty[cand]) begin
          grant_valid = 1'b1;
          grant_lane  = cand;
        end
      end
    end
  end

  assign head_sel = head[grant_lane];

  always_ff @(posedge clk4f) begin
    if (reset) begin
      data_out   <= IDLE_WORD;
      out_lane   <= '0;
      last_grant <= LANE_W'(NUM_LANES - 1);
    end else if (!out_pause) begin
      if (grant_valid) begin
        data_out   <= head_sel | (WORD_W'(1) << VALID_BIT);
        out_lane   <= grant_lane;
        last_grant <= grant_lane;
      end else begin
        data_out <= IDLE_WORD;
      end
    end
  end

endmodule

// File: doc/mux_lane_scheduler.md
# mux_lane_scheduler

Round-robin scheduler that shares the single 9-bit serial-stage datapath between the four parallel lanes (data0..data3) of the MuxesLogic path. Each lane pushes 9-bit words (bit 8 = valid, bits 7:0 = payload) into a small per-lane FIFO. The scheduler grants at most one lane per clk4f cycle onto a registered 9-bit output. It replaces the fixed 4:1 clock-phase mux selection: empty lanes are skipped, and downstream backpressure is honoured.

## Interface
- DEPTH, 4: entries per lane FIFO; power of two, ≥2.
- PRIO_MODE_EN, 1: 1 = strict-priority mode selectable via prio_mode; 0 = prio_mode ignored, always round-robin.
- clk4f  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data0..data3  input  9 each  lane words; bit 8 = push request/valid, bits 7:0 payload.
- in_ready  output  4  bit i high = lane i FIFO not full.
- out_pause  input  1  downstream stall; holds output and blocks pops.
- prio_mode  input  1  1 = strict priority, lane 0 highest.
- data_out  output  9  scheduled word; bit 8 = valid.
- out_lane  output  2  lane index of current data_out.
- occupancy  output  4*clog2(DEPTH+1)  packed per-lane FIFO counts, lane 0 in LSBs.

## Operation
- Push: lane i is written when data_i[8] && in_ready[i] at a clk4f edge. The full 9-bit word is stored. A word offered while in_ready[i] is low is dropped; the producer must hold or retry.
- in_ready[i] = (count_i != DEPTH), combinational from the registered count. A full FIFO with a same-cycle pop still shows in_ready low, so there is no pass-through.
- Grant, round-robin: search starts at last_grant+1 mod 4 and takes the first non-empty lane. After reset last_grant = 3, so lane 0 is checked first.
- Grant, strict priority (prio_mode && PRIO_MODE_EN): the lowest-index non-empty lane wins. last_grant is still updated, so returning to round-robin resumes fairly.
- prio_mode may change on any cycle; the new mode applies to the next grant decision.
- Pop: when !out_pause and a grant exists, the head of the granted lane is popped. data_out <= head word with bit 8 forced to 1, out_lane <= lane, last_grant <= lane.
- No grant and !out_pause: data_out <= 9'h000, out_lane holds its value, last_grant holds.
- out_pause high: data_out, out_lane and last_grant hold; no pops occur. Pushes continue normally.
- Simultaneous push and pop on the same lane: count is unchanged and both pointers advance.
- Pointers are clog2(DEPTH) bits and wrap naturally. Counts saturate by construction and are never allowed outside 0..DEPTH.

## Timing
- Reset (synchronous, takes effect at the edge where reset = 1):
  - data_out = 9'h000, out_lane = 2'd0, all counts and pointers = 0, last_grant = 3.
  - in_ready = 4'hF from the cycle after reset.
- Reset asserted mid-operation discards all buffered words. Pushes presented in the reset cycle are ignored.
- Latency: a word pushed at edge N into an empty lane, with no competition and no pause, appears on data_out after edge N+1 (1-cycle FIFO, 1 output register).
- Throughput: one word per cycle when any lane is non-empty and out_pause is low.
- With all four lanes continuously backlogged in round-robin mode, the output lane order is 0,1,2,3,0,…, and no lane waits more than 3 grants.

## Structure
- Package mux_sched_pkg holds:
  - NUM_LANES = 4, WORD_W = 9, VALID_BIT = 8, LANE_W = 2.
  - IDLE_WORD = 9'h000.
  - A function computing the next round-robin index.
- Sub-module lane_fifo (parameter DEPTH, WORD_W): push/pop/head/count/full/empty, synchronous active-high reset. It is instantiated four times.
- The top level holds the grant logic, the last_grant register and the output register.

## Test plan
- Reset, then push data0=9'h100, data1=9'h101, data2=9'h102, data3=9'h103 on the same edge → data_out sequence 9'h100, 9'h101, 9'h102, 9'h103 on four consecutive cycles, out_lane 0,1,2,3, then 9'h000.
- Push only data2=9'h102 and data3=9'h103 (lanes 0/1 offered with bit 8 = 0) → only 9'h102 then 9'h103; lanes 0/1 are never granted and their counts stay 0.
- Hold data1=9'h155 for DEPTH+2 cycles with out_pause=1 → in_ready[1] drops after 4 pushes and occupancy lane1 = 4. Release pause → exactly four 9'h155 outputs.
- prio_mode=1, keep lanes 0 and 3 backlogged → lane 0 is granted until empty, then lane 3. Switch to prio_mode=0 mid-stream → alternation restarts after the last granted lane.
- Assert reset for one cycle while three lanes hold 2 words each → next cycle data_out=9'h000, all occupancy 0, in_ready=4'hF, and the first subsequent grant goes to lane 0.
- Toggle out_pause every cycle with all lanes backlogged → each word appears exactly once, in order, and data_out is stable through every paused cycle.
